// File: rtl/pipeline4_if.sv
// pipeline4_if: bundle of the memory/write-back stage signals.
//   slave  : the pipeline4 stage itself
//   master : the surrounding pipeline (execute, data memory, register file, fetch)
interface pipeline4_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH     = 6,
  parameter int PC_WIDTH       = 16
);
  // upstream (execute stage) side
  logic                      valid_in;
  logic [CTRL_WIDTH-1:0]     ctrl_in;
  logic [DATA_WIDTH-1:0]     data_in;
  logic [MEM_WIDTH-1:0]      addr_in;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_in;
  logic                      pc_chg_in;
  logic [PC_WIDTH-1:0]       pc_in;
  logic                      stall;
  // data-memory port
  logic                      mem_req;
  logic                      mem_we;
  logic [MEM_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      mem_ack;
  logic                      mem_err;
  // register-file write port
  logic                      wb_en;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]     wb_data;
  // fetch redirect
  logic                      pc_chg;
  logic [PC_WIDTH-1:0]       pc_out;

  modport slave (
    input  valid_in, ctrl_in, data_in, addr_in, reg_addr_in, pc_chg_in, pc_in,
           mem_rdata, mem_ack,
    output stall, mem_req, mem_we, mem_addr, mem_wdata, mem_err,
           wb_en, wb_addr, wb_data, pc_chg, pc_out
  );

  modport master (
    output valid_in, ctrl_in, data_in, addr_in, reg_addr_in, pc_chg_in, pc_in,
           mem_rdata, mem_ack,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata, mem_err,
           wb_en, wb_addr, wb_data, pc_chg, pc_out
  );
endinterface

// File: rtl/pipeline4.sv
// pipeline4: memory-access / write-back stage behind execute.
// LW/SW run a req/ack transaction and stall upstream until done; ALU ops and
// CALL write the register file one cycle after acceptance; PC redirects are
// forwarded to fetch as one-cycle pulses. All outputs are registered.
// Optional build macro PIPELINE4_MEM_TIMEOUT_EN: bounds the mem_ack wait to
// MEM_TIMEOUT cycles and raises a sticky mem_err on expiry.
module pipeline4 #(
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH     = 6,
  parameter int PC_WIDTH       = 16,
  parameter int MEM_TIMEOUT    = 15,
  // control-word encodings shared with the rest of the pipeline
  parameter logic [CTRL_WIDTH-1:0] OP_NOP  = 6'h00,
  parameter logic [CTRL_WIDTH-1:0] OP_LW   = 6'h20,
  parameter logic [CTRL_WIDTH-1:0] OP_SW   = 6'h21,
  parameter logic [CTRL_WIDTH-1:0] OP_JR   = 6'h30,
  parameter logic [CTRL_WIDTH-1:0] OP_JPC  = 6'h31,
  parameter logic [CTRL_WIDTH-1:0] OP_BRFL = 6'h32,
  parameter logic [CTRL_WIDTH-1:0] OP_CALL = 6'h33,
  parameter logic [CTRL_WIDTH-1:0] OP_RET  = 6'h34
) (
  input  logic        clk_in,
  input  logic        RST,
  pipeline4_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, WB} state_t;
  state_t state;

  // Control-flow-only and NOP words never touch the register file; every
  // other non-memory word (ALU ops, CALL) writes back.
  logic no_wb;
  assign no_wb = (bus.ctrl_in == OP_JR)  || (bus.ctrl_in == OP_JPC) ||
                 (bus.ctrl_in == OP_BRFL) || (bus.ctrl_in == OP_RET) ||
                 (bus.ctrl_in == OP_NOP);

`ifdef PIPELINE4_MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  // The wait has lasted MEM_TIMEOUT request cycles once the count sits at
  // MEM_TIMEOUT-1 with still no ack.
  assign tmo_hit = (tmo_cnt == TW'(MEM_TIMEOUT - 1));
`else
  localparam int unused_mem_timeout = MEM_TIMEOUT;
`endif

  // Stage FSM: owns every registered output.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      state         <= IDLE;
      bus.stall     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_err   <= 1'b0;
      bus.wb_en     <= 1'b0;
      bus.wb_addr   <= '0;
      bus.wb_data   <= '0;
      bus.pc_chg    <= 1'b0;
      bus.pc_out    <= '0;
`ifdef PIPELINE4_MEM_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      // write-back and redirect are pulses unless re-asserted below
      bus.wb_en  <= 1'b0;
      bus.pc_chg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            if (bus.pc_chg_in) begin
              bus.pc_chg <= 1'b1;
              bus.pc_out <= bus.pc_in;
            end
            if (bus.ctrl_in == OP_LW) begin
              state        <= RD_WAIT;
              bus.mem_req  <= 1'b1;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.addr_in;
              bus.wb_addr  <= bus.reg_addr_in;
              bus.stall    <= 1'b1;
`ifdef PIPELINE4_MEM_TIMEOUT_EN
              tmo_cnt      <= '0;
`endif
            end else if (bus.ctrl_in == OP_SW) begin
              state         <= WR_WAIT;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= bus.addr_in;
              bus.mem_wdata <= bus.data_in;
              bus.stall     <= 1'b1;
`ifdef PIPELINE4_MEM_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
            end else if (!no_wb) begin
              bus.wb_en   <= 1'b1;
              bus.wb_addr <= bus.reg_addr_in;
              bus.wb_data <= bus.data_in;
            end
          end
        end
        RD_WAIT: begin
          // load data lands in wb_data now so WB only has to release stall
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.wb_en   <= 1'b1;
            bus.wb_data <= bus.mem_rdata;
            state       <= WB;
          end
`ifdef PIPELINE4_MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            bus.mem_req <= 1'b0;
            bus.mem_err <= 1'b1;
            bus.stall   <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        WR_WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.stall   <= 1'b0;
            state       <= IDLE;
          end
`ifdef PIPELINE4_MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.mem_err <= 1'b1;
            bus.stall   <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        WB: begin
          bus.stall <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline4.sv
// tb_pipeline4: table-driven single-cycle ops plus hand-written LW/SW/reset
// sequences; write-backs and redirects are checked against scoreboard queues.
module tb_pipeline4;
  localparam int DW = 16, MW = 16, RW = 4, CW = 6, PW = 16;
`ifdef PIPELINE4_MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 15;
`endif
  localparam logic [CW-1:0] NOP = 6'h00, LW = 6'h20, SW = 6'h21, JR = 6'h30,
                            JPC = 6'h31, BRFL = 6'h32, CALL = 6'h33, RET = 6'h34,
                            ADD = 6'h01, SUB = 6'h05;
  localparam logic [RW-1:0] REG_FUNC_RET = 4'hE;

  logic clk_in = 1'b0;
  logic RST;
  always #5 clk_in = ~clk_in;

  pipeline4_if #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .REG_ADDR_WIDTH(RW),
                 .CTRL_WIDTH(CW), .PC_WIDTH(PW)) bus ();

  pipeline4 #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .REG_ADDR_WIDTH(RW),
              .CTRL_WIDTH(CW), .PC_WIDTH(PW), .MEM_TIMEOUT(TMO),
              .OP_NOP(NOP), .OP_LW(LW), .OP_SW(SW), .OP_JR(JR), .OP_JPC(JPC),
              .OP_BRFL(BRFL), .OP_CALL(CALL), .OP_RET(RET))
    dut (.clk_in(clk_in), .RST(RST), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // scoreboard
  typedef struct { logic [RW-1:0] a; logic [DW-1:0] d; } wb_t;
  wb_t            wb_q[$];
  logic [PW-1:0]  pc_q[$];

  always @(negedge clk_in) begin
    if (!RST) begin
      if (bus.wb_en) begin
        if (wb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wb_unexpected: got wb_en=1 addr=%h data=%h, expected none", bus.wb_addr, bus.wb_data);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          chk("sb_wb_addr", 32'(bus.wb_addr), 32'(e.a));
          chk("sb_wb_data", 32'(bus.wb_data), 32'(e.d));
        end
      end
      if (bus.pc_chg) begin
        if (pc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pc_unexpected: got pc_chg=1 pc_out=%h, expected none", bus.pc_out);
        end else begin
          logic [PW-1:0] p;
          p = pc_q.pop_front();
          chk("sb_pc_out", 32'(bus.pc_out), 32'(p));
        end
      end
    end
  end

  typedef struct {
    logic [CW-1:0] ctrl; logic [DW-1:0] data; logic [RW-1:0] ra;
    logic pcc; logic [PW-1:0] pc; logic exp_wb; logic exp_pc;
  } vec_t;
  vec_t vecs[8];

  task automatic drive(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [MW-1:0] a,
                       input logic [RW-1:0] ra, input logic pcc, input logic [PW-1:0] pc);
    bus.valid_in = 1'b1; bus.ctrl_in = c; bus.data_in = d; bus.addr_in = a;
    bus.reg_addr_in = ra; bus.pc_chg_in = pcc; bus.pc_in = pc;
  endtask

  initial begin
    int stall_cnt, req_cnt;
    vecs[0] = '{ADD,  16'h1234, 4'd3,         1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{SUB,  16'hFFFF, 4'd15,        1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{NOP,  16'h5555, 4'd1,         1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{JR,   16'h0000, 4'd2,         1'b1, 16'h0200, 1'b0, 1'b1};
    vecs[4] = '{CALL, 16'h0007, REG_FUNC_RET, 1'b1, 16'h0100, 1'b1, 1'b1};
    vecs[5] = '{RET,  16'h9999, 4'd4,         1'b1, 16'h0050, 1'b0, 1'b1};
    vecs[6] = '{BRFL, 16'h1111, 4'd6,         1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{JPC,  16'h2222, 4'd7,         1'b1, 16'hABCD, 1'b0, 1'b1};

    bus.valid_in = 0; bus.ctrl_in = '0; bus.data_in = '0; bus.addr_in = '0;
    bus.reg_addr_in = '0; bus.pc_chg_in = 0; bus.pc_in = '0;
    bus.mem_rdata = '0; bus.mem_ack = 0;
    RST = 1;
    tick(); tick();
    chk("rst_ctl", 32'({bus.stall, bus.mem_req, bus.mem_we, bus.wb_en, bus.pc_chg, bus.mem_err}), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata_wbaddr", 32'({bus.mem_wdata, bus.wb_addr}), 32'd0);
    chk("rst_wb_pc", {bus.wb_data, bus.pc_out}, 32'd0);
    RST = 0;

    // single-cycle ops
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].ctrl, vecs[i].data, 16'h0, vecs[i].ra, vecs[i].pcc, vecs[i].pc);
      if (vecs[i].exp_wb) wb_q.push_back('{vecs[i].ra, vecs[i].data});
      if (vecs[i].exp_pc) pc_q.push_back(vecs[i].pc);
      tick();
      chk($sformatf("v%0d_wb_en", i), 32'(bus.wb_en), 32'(vecs[i].exp_wb));
      chk($sformatf("v%0d_pc_chg", i), 32'(bus.pc_chg), 32'(vecs[i].exp_pc));
      chk($sformatf("v%0d_stall_req", i), 32'({bus.stall, bus.mem_req}), 32'd0);
      bus.valid_in = 0;
      tick();
      chk($sformatf("v%0d_pulse", i), 32'({bus.wb_en, bus.pc_chg}), 32'd0);
    end

    // ack with no request is ignored
    bus.mem_ack = 1; tick(); bus.mem_ack = 0;
    chk("stray_ack", 32'({bus.stall, bus.mem_req, bus.wb_en}), 32'd0);

    // LW, ack on 3rd request cycle; junk ADD held valid during the stall
    drive(LW, 16'h0000, 16'h0040, 4'd5, 1'b0, 16'h0);
    wb_q.push_back('{4'd5, 16'hBEEF});
    stall_cnt = 0; req_cnt = 0;
    tick();
    chk("lw_addr_we", 32'({bus.mem_addr, 15'd0, bus.mem_we}), {16'h0040, 16'h0000});
    drive(ADD, 16'hDEAD, 16'h0, 4'd9, 1'b0, 16'h0);
    for (int c = 1; c <= 5; c++) begin
      stall_cnt += int'(bus.stall);
      req_cnt   += int'(bus.mem_req);
      bus.mem_ack = (c == 3); bus.mem_rdata = (c == 3) ? 16'hBEEF : 16'h0BAD;
      if (c == 4) bus.valid_in = 0;
      tick();
      bus.mem_ack = 0;
      if (c == 3) chk("lw_wb_en", 32'(bus.wb_en), 32'd1);
    end
    chk("lw_req_cycles", 32'(req_cnt), 32'd3);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lw_done_idle", 32'({bus.stall, bus.mem_req, bus.wb_en}), 32'd0);

    // SW zero wait
    drive(SW, 16'h00AA, 16'h0010, 4'd0, 1'b0, 16'h0);
    tick();
    bus.valid_in = 0;
    chk("sw_req", 32'({bus.mem_req, bus.mem_we, bus.stall}), 32'b111);
    chk("sw_addr_data", {bus.mem_addr, bus.mem_wdata}, {16'h0010, 16'h00AA});
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    chk("sw_done", 32'({bus.mem_req, bus.mem_we, bus.stall, bus.wb_en}), 32'd0);
    tick();
    chk("sw_no_wb", 32'(bus.wb_en), 32'd0);

`ifndef PIPELINE4_MEM_TIMEOUT_EN
    // long wait never times out in the default build
    drive(LW, 16'h0, 16'h0123, 4'd9, 1'b0, 16'h0);
    wb_q.push_back('{4'd9, 16'h4321});
    tick();
    bus.valid_in = 0;
    repeat (20) tick();
    chk("long_wait_req", 32'({bus.mem_req, bus.stall, bus.mem_err}), 32'b110);
    bus.mem_ack = 1; bus.mem_rdata = 16'h4321;
    tick();
    bus.mem_ack = 0;
    chk("long_wait_wb", 32'(bus.wb_en), 32'd1);
    tick();
    chk("long_wait_done", 32'(bus.stall), 32'd0);
`else
    // unanswered LW times out after TMO request cycles
    drive(LW, 16'h0, 16'h0123, 4'd9, 1'b0, 16'h0);
    tick();
    bus.valid_in = 0;
    req_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      req_cnt += int'(bus.mem_req);
      tick();
    end
    chk("tmo_req_cycles", 32'(req_cnt), 32'(TMO));
    chk("tmo_err", 32'({bus.mem_err, bus.stall, bus.mem_req, bus.wb_en}), 32'b1000);
    drive(ADD, 16'h3C3C, 16'h0, 4'd8, 1'b0, 16'h0);
    wb_q.push_back('{4'd8, 16'h3C3C});
    tick();
    bus.valid_in = 0;
    chk("tmo_add_wb", 32'({bus.wb_en, bus.mem_err}), 32'b11);
`endif

    // reset during the 2nd RD_WAIT cycle, late ack ignored
    drive(LW, 16'h0, 16'h0080, 4'd7, 1'b0, 16'h0);
    tick();
    bus.valid_in = 0;
    tick();
    RST = 1;
    tick();
    chk("rstmid_ctl", 32'({bus.stall, bus.mem_req, bus.mem_we, bus.wb_en, bus.pc_chg, bus.mem_err}), 32'd0);
    chk("rstmid_data", {bus.mem_addr, bus.wb_data}, 32'd0);
    RST = 0;
    bus.mem_ack = 1; bus.mem_rdata = 16'hBAD0;
    tick(); tick();
    bus.mem_ack = 0;
    chk("rstmid_no_wb", 32'({bus.wb_en, bus.mem_req, bus.stall}), 32'd0);
    drive(ADD, 16'h5A5A, 16'h0, 4'd2, 1'b0, 16'h0);
    wb_q.push_back('{4'd2, 16'h5A5A});
    tick();
    bus.valid_in = 0;
    chk("rstmid_add", 32'(bus.wb_en), 32'd1);
    tick(); tick();

    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    chk("pc_q_drained", 32'(pc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline4.md
Name: pipeline4

Overview:
- Memory-access / write-back stage directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: computed data, memory address, destination register, control word, PC-change request and done flag.
- For LW/SW, runs a req/ack transaction on the data-memory port and stalls upstream until it completes.
- For ALU ops and CALL, issues a one-cycle register-file write. Forwards PC redirects to fetch.

Parameters:
- DATA_WIDTH, 16, data/register width
- MEM_WIDTH, 16, data-memory address width
- REG_ADDR_WIDTH, 4, register-file address width
- CTRL_WIDTH, 6, control-word width; LW/SW/JR/JPC/BRFL/CALL/RET/NOP encodings come from the shared instruction parameter file
- PC_WIDTH, 16, program-counter width
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ack (used only with optional feature)

Ports:
- clk_in  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- valid_in  in  1  upstream outputs stable (execute stage done)
- ctrl_in  in  CTRL_WIDTH  control word from execute
- data_in  in  DATA_WIDTH  ALU result / store data
- addr_in  in  MEM_WIDTH  computed memory address
- reg_addr_in  in  REG_ADDR_WIDTH  destination register
- pc_chg_in  in  1  PC redirect request
- pc_in  in  PC_WIDTH  redirect target
- stall  out  1  freeze upstream stages
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  MEM_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  store data
- mem_rdata  in  DATA_WIDTH  load data, valid with mem_ack
- mem_ack  in  1  transaction complete
- wb_en  out  1  register-file write strobe
- wb_addr  out  REG_ADDR_WIDTH  write address
- wb_data  out  DATA_WIDTH  write data
- pc_chg  out  1  redirect pulse to fetch
- pc_out  out  PC_WIDTH  redirect target
- mem_err  out  1  memory timeout flag

Behaviour:
Reset and outputs
- All outputs are registered.
- On RST=1 at a clock edge: state=IDLE; stall, mem_req, mem_we, wb_en, pc_chg, mem_err=0; mem_addr, mem_wdata, wb_addr, wb_data, pc_out=0.
- RST wins over every other event. A transaction in flight is abandoned: mem_req drops on the reset edge and any later ack is ignored.

States: IDLE, RD_WAIT, WR_WAIT, WB.

IDLE
- Accepts an instruction at an edge with valid_in=1.
- ALU ops and CALL: next cycle wb_en=1, wb_addr=reg_addr_in, wb_data=data_in (latency 1). State stays IDLE.
- LW: → RD_WAIT; mem_req=1, mem_we=0, mem_addr=addr_in; wb_addr latched; stall=1.
- SW: → WR_WAIT; mem_req=1, mem_we=1, mem_addr=addr_in, mem_wdata=data_in; stall=1.
- JR, JPC, BRFL, RET, NOP: no write-back, no memory access.
- pc_chg_in=1 with valid_in: pc_chg=1, pc_out=pc_in for exactly one cycle, independent of write-back. CALL produces both wb_en and pc_chg in the same cycle.
- valid_in=0: wb_en, pc_chg=0.

RD_WAIT
- mem_req and the address are held stable until mem_ack=1. mem_ack is sampled only while mem_req=1; ack in the first req cycle is legal (zero wait-state).
- On ack: capture mem_rdata, drop mem_req → WB.

WB
- wb_en=1, wb_data=captured rdata for one cycle; stall=0 → IDLE.
- Minimum LW occupancy: accept edge + 1 req cycle + 1 WB cycle.

WR_WAIT
- On ack: drop mem_req and mem_we, stall=0 → IDLE. No write-back.

General
- stall=1 from the edge entering RD_WAIT/WR_WAIT until the edge leaving RD_WAIT/WB/WR_WAIT respectively.
- While stall=1, inputs are ignored; upstream holds them.
- mem_ack while mem_req=0 is ignored.
- wb_en and pc_chg are single-cycle pulses, never held.

Optional Feature:
- Macro PIPELINE4_MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to RD_WAIT/WR_WAIT and increments each cycle without ack. When it reaches MEM_TIMEOUT, the block drops mem_req, sets mem_err=1 (sticky until RST), returns to IDLE with stall=0, and issues no write-back. An ack on the same cycle as timeout takes priority (normal completion).
- Undefined: no counter; wait is unbounded; mem_err tied 0.

Test Plan:
- ADD: ctrl=ADD, data_in=0x1234, reg_addr_in=3, valid_in=1 → next cycle wb_en=1, wb_addr=3, wb_data=0x1234, stall=0, mem_req=0.
- LW with 2 wait states: addr_in=0x0040, reg_addr_in=5; mem_ack on the 3rd req cycle with rdata=0xBEEF → mem_req high 3 cycles, then wb_en=1, wb_addr=5, wb_data=0xBEEF; stall high 4 cycles total.
- SW zero wait: addr_in=0x0010, data_in=0x00AA, ack in the first req cycle → mem_we=1 with mem_wdata=0x00AA for 1 cycle; wb_en never asserts; stall 1 cycle.
- CALL: data_in=0x0007, reg_addr_in=REG_FUNC_RET, pc_chg_in=1, pc_in=0x0100 → same cycle wb_en=1 with wb_data=0x0007, and pc_chg=1 with pc_out=0x0100, both single pulses.
- Reset mid-LW: RST=1 during the 2nd RD_WAIT cycle, then ack after → all outputs 0, state IDLE, no wb_en.
- With PIPELINE4_MEM_TIMEOUT_EN and MEM_TIMEOUT=4: LW never acked → mem_req drops after 4 cycles, mem_err=1 and stays set, no wb_en; the next ADD writes back normally.
